set_clr_sequencer: RTL

- Generates the set/clear pulse pair that drives the latch stage directly downstream: `set_o` goes to its `input_a` and `clr_o` goes to its `input_b`.
- Accepts one request at a time over a valid/ready handshake. Each request carries a busy length in cycles.
- Runs a four-state FSM: pulse set, hold for the programmed length, pulse clear, return to idle.
- An abort input cuts the busy hold short and still issues the clear pulse.

---
 rtl/set_clr_sequencer.sv | 79 +++++++
 1 files changed

// File: rtl/set_clr_sequencer.sv
// rtl/set_clr_sequencer.sv - set/clear pulse sequencer with programmable busy hold and abort
module set_clr_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CNT_W-1:0] req_len,
    input  logic             abort,
    output logic             set_o,
    output logic             clr_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             aborted_o,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_START = 2'b01,
        S_BUSY  = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             aborted;

    // START and BUSY share the exit rule; START always spends its one cycle
    // before any hold, so the decrement there is what makes BUSY last req_len.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= CNT_ZERO;
            aborted <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        cnt     <= req_len;
                        aborted <= 1'b0;
                        state   <= S_START;
                    end
                end
                S_START, S_BUSY: begin
                    if (abort) begin
                        aborted <= 1'b1;
                        state   <= S_DONE;
                    end else if (cnt == CNT_ZERO) begin
                        state   <= S_DONE;
                    end else begin
                        cnt     <= cnt - CNT_ONE;
                        state   <= S_BUSY;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Moore decode from the state flops only; nothing here sees an input.
    assign req_ready = (state == S_IDLE);
    assign set_o     = (state == S_START);
    assign busy_o    = (state == S_START) || (state == S_BUSY);
    assign clr_o     = (state == S_DONE);
    assign done_o    = (state == S_DONE);
    assign aborted_o = aborted;
    assign state_o   = state;

endmodule
